// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), behind a valid/ready handshake.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alucnt,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   hi,
    output logic               zero,
    output logic               ovf,
    output logic               dbz,
    output logic               illegal,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE, and the
    // DONE outputs hold steady until out_ready is seen high.

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             b_is_zero;
    logic             is_mul;
    logic             is_div;
    logic             last_step;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_illegal;

    // Iteration registers: work_hi holds partial product / remainder,
    // work_lo holds the multiplier / dividend-turning-into-quotient.
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;

    assign accept    = in_valid && in_ready;
    assign b_is_zero = (input2 == '0);
    assign is_mul    = (alucnt == OP_MULU);
    assign is_div    = (alucnt == OP_DIVU);
    assign last_step = (count == CNT_W'(WIDTH - 1));

    // ---------------- single-cycle operations ----------------
    always_comb begin
        sum         = input1 + input2;
        diff        = input1 - input2;
        alu_res     = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (alucnt)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                          (sum[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                          (diff[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_NOT:  alu_res = ~input1;
            OP_SLL:  alu_res = input1 << shamt;
            OP_SRL:  alu_res = input1 >> shamt;
            OP_AND:  alu_res = input1 & input2;
            OP_OR:   alu_res = input1 | input2;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            OP_SRA:  alu_res = $signed(input1) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            OP_XOR:  alu_res = input1 ^ input2;
            OP_NOR:  alu_res = ~(input1 | input2);
            OP_MULU: alu_res = '0;
            OP_DIVU: alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // ---------------- one shift-add multiply step ----------------
    always_comb begin
        mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};
    end

    // ---------------- one restoring divide step ----------------
    // The shifted remainder is always below 2*divisor, so the subtracted value
    // fits back into WIDTH bits.
    always_comb begin
        div_shift = {work_hi, work_lo[WIDTH-1]};
        if (div_shift >= {1'b0, opnd}) begin
            div_rem_next = div_shift[WIDTH-1:0] - opnd;
            div_quo_next = {work_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_next = div_shift[WIDTH-1:0];
            div_quo_next = {work_lo[WIDTH-2:0], 1'b0};
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_next = S_MUL;
                    end else if (is_div && !b_is_zero) begin
                        state_next = S_DIV;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (last_step) state_next = S_DONE;
            end
            S_DIV: begin
                if (last_step) state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        dbg_state = state;
    end

    // ---------------- datapath and result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            work_hi <= '0;
            work_lo <= '0;
            opnd    <= '0;
            count   <= '0;
            result  <= '0;
            hi      <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            dbz     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count   <= '0;
                        work_hi <= '0;
                        if (is_mul) begin
                            work_lo <= input2;
                            opnd    <= input1;
                        end else begin
                            work_lo <= input1;
                            opnd    <= input2;
                        end
                        if (is_mul || (is_div && !b_is_zero)) begin
                            result  <= '0;
                            hi      <= '0;
                            zero    <= 1'b0;
                            ovf     <= 1'b0;
                            dbz     <= 1'b0;
                            illegal <= 1'b0;
                        end else if (is_div) begin
                            result  <= '1;
                            hi      <= input1;
                            zero    <= 1'b0;
                            ovf     <= 1'b0;
                            dbz     <= 1'b1;
                            illegal <= 1'b0;
                        end else begin
                            result  <= alu_res;
                            hi      <= '0;
                            zero    <= (alu_res == '0);
                            ovf     <= alu_ovf;
                            dbz     <= 1'b0;
                            illegal <= alu_illegal;
                        end
                    end
                end
                S_MUL: begin
                    work_hi <= mul_hi_next;
                    work_lo <= mul_lo_next;
                    count   <= count + 1'b1;
                    if (last_step) begin
                        result <= mul_lo_next;
                        hi     <= mul_hi_next;
                        zero   <= (mul_lo_next == '0);
                    end
                end
                S_DIV: begin
                    work_hi <= div_rem_next;
                    work_lo <= div_quo_next;
                    count   <= count + 1'b1;
                    if (last_step) begin
                        result <= div_quo_next;
                        hi     <= div_rem_next;
                        zero   <= (div_quo_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
